// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop,
// sequenced LSB first over WIDTH clock cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic [CW-1:0]    count;
    logic             carry;
    logic             carry_nxt;
    logic             bit_s;
    logic             last;
    logic             load;

    // Full-adder slice on the current LSBs and next partial-sum value
    always_comb begin
        bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        psum_nxt  = psum >> 1;
        psum_nxt[WIDTH-1] = bit_s;
        last      = (count == CW'(WIDTH - 1));
        load      = start && ((state == IDLE) || (state == DONE));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; status depends only on state
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            psum  <= '0;
            count <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= carry_nxt;
            psum  <= psum_nxt;
            count <= count + CW'(1);
            if (last) begin
                sum  <= psum_nxt;
                cout <= carry_nxt;
            end
        end
    end

endmodule
